// File: rtl/eth_rx_axis_upsizer.sv
// Packs the MAC RX byte stream into OUT_BYTES-wide AXI-Stream words, with one word of output buffering.
// Optional frame statistics are enabled by defining ETH_RX_STATS_EN.
module eth_rx_axis_upsizer #(
    parameter int OUT_BYTES  = 4,
    parameter int DATA_WIDTH = 8 * OUT_BYTES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [OUT_BYTES-1:0]  m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic                  clear_stats,
    output logic [15:0]           status_vector
);

    localparam int LW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [OUT_BYTES-1:0]  tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;

    logic                  accept;
    logic                  last_lane;
    logic                  word_done;
    logic                  out_hs;
    logic [DATA_WIDTH-1:0] merged;
    logic [OUT_BYTES-1:0]  lane_keep;

    assign s_axis_tready = !tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign last_lane     = (lane_q == LW'(OUT_BYTES - 1));
    assign word_done     = accept && (last_lane || s_axis_tlast);
    assign out_hs        = tvalid_q && m_axis_tready;

    // Accumulator lanes above the current one are always zero, so the merged word is already zero-padded.
    for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
        assign merged[gi*8 +: 8] = (lane_q == LW'(gi)) ? s_axis_tdata : acc_q[gi*8 +: 8];
        assign lane_keep[gi]     = (LW'(gi) <= lane_q);
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        acc_d    = acc_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (out_hs) begin
            tvalid_d = 1'b0;
        end
        if (accept) begin
            state_d = s_axis_tlast ? IDLE : FRAME;
            if (word_done) begin
                lane_d   = '0;
                acc_d    = '0;
                tdata_d  = merged;
                tkeep_d  = lane_keep;
                tvalid_d = 1'b1;
                tlast_d  = s_axis_tlast;
                tuser_d  = s_axis_tlast && s_axis_tuser;
            end else begin
                lane_d = lane_q + LW'(1);
                acc_d  = merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

`ifdef ETH_RX_STATS_EN
    logic [7:0] good_q, good_d;
    logic [7:0] bad_q, bad_d;

    // Frames are counted as they leave on m_axis; a clear in the same cycle wins.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (clear_stats) begin
            good_d = '0;
            bad_d  = '0;
        end else if (out_hs && tlast_q) begin
            if (tuser_q) begin
                bad_d = (bad_q == 8'hFF) ? bad_q : bad_q + 8'd1;
            end else begin
                good_d = good_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign status_vector = {bad_q, good_q};
`else
    logic stats_unused;
    assign stats_unused  = clear_stats;
    assign status_vector = 16'd0;
`endif

endmodule

// File: doc/eth_rx_axis_upsizer.md
ETH_RX_AXIS_UPSIZER -- requirements
Module: eth_rx_axis_upsizer

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 4, output word width in bytes; legal 1..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8*OUT_BYTES, derived and not overridden.
REQ-003 SHALL have port clock  input  1  single clock; all logic is in this domain.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports s_axis_tdata/tvalid/tlast/tuser  input  8/1/1/1  byte stream from the MAC RX FIFO; tuser=1 on tlast marks a bad frame.
REQ-006 SHALL have port s_axis_tready  output  1.
REQ-007 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast/tuser  output  DATA_WIDTH/OUT_BYTES/1/1/1  packed word stream.
REQ-008 SHALL have port m_axis_tready  input  1.
REQ-009 SHALL have port clear_stats  input  1  single-cycle counter clear.
REQ-010 SHALL have port status_vector  output  16  {bad_frames[7:0], good_frames[7:0]}.

Function
REQ-011 SHALL accept a byte when s_axis_tvalid && s_axis_tready, with s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-012 SHALL place the first byte of each word in lane 0 (bits 7:0) and subsequent bytes in ascending lanes.
REQ-013 SHALL keep a lane counter 0..OUT_BYTES-1; a word completes when the accepted byte has lane OUT_BYTES-1 or tlast=1.
REQ-014 SHALL load the completed word into the output register on the clock edge that accepts the completing byte; m_axis_tvalid rises the next cycle (latency 1).
REQ-015 SHALL drive m_axis_tkeep with contiguous ones from lane 0 up to the last filled lane; non-final words have all ones.
REQ-016 SHALL drive m_axis_tlast and m_axis_tuser from the completing byte's tlast/tuser; m_axis_tuser=0 on non-final words.
REQ-017 SHALL zero the unfilled lanes of m_axis_tdata.
REQ-018 SHALL hold m_axis_tdata/tkeep/tlast/tuser stable while m_axis_tvalid && !m_axis_tready.
REQ-019 SHALL clear m_axis_tvalid after a handshake unless a new word is loaded in the same cycle (back-to-back words at full rate).
REQ-020 SHALL reset the lane counter to 0 after every tlast; a frame starts in lane 0.
REQ-021 SHALL, with OUT_BYTES=1, pass bytes through with tkeep=1 and latency 1.
REQ-022 SHALL enter state IDLE (lane 0, no frame open) or FRAME (lane>0 or mid-frame); IDLE->FRAME on a non-tlast accepted byte, FRAME->IDLE on an accepted tlast byte.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, set m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, lane counter=0, state=IDLE, status_vector=0.
REQ-024 SHALL discard any partially packed word on reset mid-frame; the next accepted byte starts a new frame in lane 0.
REQ-025 SHALL drive s_axis_tready=1 in the first cycle after reset release.

Configuration
REQ-026 SHALL, with macro ETH_RX_STATS_EN defined, count good_frames (tlast handshake on m_axis with tuser=0, wrapping modulo 256) and bad_frames (tuser=1, saturating at 255).
REQ-027 SHALL, with ETH_RX_STATS_EN defined, zero both counters on clear_stats=1; clear takes priority over a same-cycle frame end, which is not counted.
REQ-028 SHALL, without ETH_RX_STATS_EN, tie status_vector to 0, ignore clear_stats, and synthesise no counter logic.

Verification
REQ-029 SHALL verify (OUT_BYTES=4): 6-byte frame 01..06, m_axis_tready=1 -> words 0x04030201 keep 0xF tlast 0, then 0x00000605 keep 0x3 tlast 1.
REQ-030 SHALL verify: 8-byte frame with m_axis_tready held 0 for 5 cycles -> s_axis_tready=0 after first word, data held stable, no byte lost, two words keep 0xF.
REQ-031 SHALL verify: 1-byte frame 0xAA tuser=1 -> one word 0x000000AA keep 0x1 tlast 1 tuser 1; with ETH_RX_STATS_EN status_vector=0x0100.
REQ-032 SHALL verify: reset_n=0 after 3 bytes of a frame, then new frame 11..14 -> single word 0x14131211 keep 0xF tlast 1, no stale bytes.
REQ-033 SHALL verify (ETH_RX_STATS_EN): 257 good frames -> status_vector[7:0]=0x01; 300 bad frames -> [15:8]=0xFF; clear_stats with a frame end in the same cycle -> 0x0000.
REQ-034 SHALL verify continuous 64-byte frames back-to-back with m_axis_tready=1 -> s_axis_tready constant 1, one word every 4 cycles.
